// File: rtl/pmu_regex_param.sv
// rtl/pmu_regex_param.sv - Parametrised rate-1/2 Viterbi add-compare-select and path-metric unit
// Register-exchange survivors, normalised saturating metrics, full-state argmin every accepted step.
module pmu_regex_param #(
  parameter int K       = 7,
  parameter int BM_W    = 4,
  parameter int PM_W    = 12,
  parameter int DEPTH   = 60,
  parameter int PM_INIT = 2 ** (PM_W - 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          flush_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [(2**(K-1))*BM_W-1:0]    bm0_i,
  input  logic [(2**(K-1))*BM_W-1:0]    bm1_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          data_o,
  output logic [K-2:0]                  min_idx_o,
  output logic [PM_W-1:0]               pm_min_o
);
  localparam int STATES = 2 ** (K - 1);
  localparam int HALF   = STATES / 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam logic [PM_W-1:0]  PM_MAX    = {PM_W{1'b1}};
  localparam logic [PM_W-1:0]  PM_INIT_V = PM_W'(PM_INIT);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_OUT   = CNT_W'(DEPTH - 1);

  logic [PM_W-1:0]  pm_q     [STATES];
  logic [PM_W-1:0]  pm_d     [STATES];
  logic [DEPTH-1:0] surv_q   [STATES];
  logic [DEPTH-1:0] surv_d   [STATES];
  logic [PM_W-1:0]  pm_new   [STATES];
  logic [DEPTH-1:0] surv_new [STATES];
  logic [PM_W-1:0]  pm_min_q, pm_min_d;
  logic [K-2:0]     min_idx_q, min_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             data_q, data_d;
  logic             acc;
  logic [PM_W-1:0]  best_pm;
  logic [K-2:0]     best_idx;

  // pm_min is the minimum of the stored metrics, so pm - pm_min never underflows.
  function automatic logic [PM_W-1:0] branch_cost(input logic [PM_W-1:0] pm,
                                                  input logic [PM_W-1:0] pm_min,
                                                  input logic [BM_W-1:0] bm);
    logic [PM_W-1:0] diff;
    logic [PM_W:0]   sum;
    diff = pm - pm_min;
    sum  = {1'b0, diff} + {{(PM_W + 1 - BM_W){1'b0}}, bm};
    return sum[PM_W] ? PM_MAX : sum[PM_W-1:0];
  endfunction

  assign ready_o = !(valid_q && !ready_i);
  assign acc     = valid_i && ready_o;

  always_comb begin
    logic [PM_W-1:0] c_a;
    logic [PM_W-1:0] c_b;
    c_a      = '0;
    c_b      = '0;
    pm_new   = pm_q;
    surv_new = surv_q;
    for (int s = 0; s < HALF; s++) begin
      c_a = branch_cost(pm_q[2*s], pm_min_q, bm0_i[(2*s)*BM_W +: BM_W]);
      c_b = branch_cost(pm_q[2*s+1], pm_min_q, bm0_i[(2*s+1)*BM_W +: BM_W]);
      if (c_b < c_a) begin
        pm_new[s]   = c_b;
        surv_new[s] = {surv_q[2*s+1][DEPTH-2:0], 1'b0};
      end else begin
        pm_new[s]   = c_a;
        surv_new[s] = {surv_q[2*s][DEPTH-2:0], 1'b0};
      end
      c_a = branch_cost(pm_q[2*s], pm_min_q, bm1_i[(2*s)*BM_W +: BM_W]);
      c_b = branch_cost(pm_q[2*s+1], pm_min_q, bm1_i[(2*s+1)*BM_W +: BM_W]);
      if (c_b < c_a) begin
        pm_new[s+HALF]   = c_b;
        surv_new[s+HALF] = {surv_q[2*s+1][DEPTH-2:0], 1'b1};
      end else begin
        pm_new[s+HALF]   = c_a;
        surv_new[s+HALF] = {surv_q[2*s][DEPTH-2:0], 1'b1};
      end
    end
  end

  always_comb begin
    best_pm  = pm_new[0];
    best_idx = '0;
    for (int i = 1; i < STATES; i++) begin
      if (pm_new[i] < best_pm) begin
        best_pm  = pm_new[i];
        best_idx = (K-1)'(i);
      end
    end
  end

  always_comb begin
    pm_d      = pm_q;
    surv_d    = surv_q;
    pm_min_d  = pm_min_q;
    min_idx_d = min_idx_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    data_d    = data_q;
    if (flush_i) begin
      for (int i = 0; i < STATES; i++) begin
        pm_d[i]   = (i == 0) ? '0 : PM_INIT_V;
        surv_d[i] = '0;
      end
      pm_min_d  = '0;
      min_idx_d = '0;
      cnt_d     = '0;
      valid_d   = 1'b0;
      data_d    = 1'b0;
    end else if (acc) begin
      pm_d      = pm_new;
      surv_d    = surv_new;
      pm_min_d  = best_pm;
      min_idx_d = best_idx;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      valid_d = (cnt_q >= CNT_OUT);
      if (cnt_q >= CNT_OUT) data_d = surv_new[best_idx][DEPTH-1];
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < STATES; i++) begin
        pm_q[i]   <= (i == 0) ? '0 : PM_INIT_V;
        surv_q[i] <= '0;
      end
      pm_min_q  <= '0;
      min_idx_q <= '0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      data_q    <= 1'b0;
    end else begin
      pm_q      <= pm_d;
      surv_q    <= surv_d;
      pm_min_q  <= pm_min_d;
      min_idx_q <= min_idx_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
    end
  end

  assign valid_o   = valid_q;
  assign data_o    = data_q;
  assign min_idx_o = min_idx_q;
  assign pm_min_o  = pm_min_q;

endmodule

// File: tb/tb_pmu_regex_param.sv
// tb/tb_pmu_regex_param.sv - Directed self-checking bench for pmu_regex_param
// K=3, DEPTH=4, PM_W=6, PM_INIT=60 so metric saturation is reachable.
module tb_pmu_regex_param;
  localparam int K       = 3;
  localparam int BM_W    = 4;
  localparam int PM_W    = 6;
  localparam int DEPTH   = 4;
  localparam int PM_INIT = 60;
  localparam int STATES  = 4;

  logic                    clk_i = 1'b0;
  logic                    rst_i, flush_i, valid_i, ready_i;
  logic                    ready_o, valid_o, data_o;
  logic [STATES*BM_W-1:0]  bm0_i, bm1_i;
  logic [K-2:0]            min_idx_o;
  logic [PM_W-1:0]         pm_min_o;
  int                      n_checks = 0;
  int                      n_errors = 0;

  int bits     [8] = '{1, 0, 1, 1, 0, 0, 0, 0};
  int exp_data [5] = '{1, 0, 1, 1, 0};
  int exp_idx  [5] = '{3, 1, 0, 0, 0};

  always #5 clk_i = ~clk_i;

  pmu_regex_param #(
    .K(K), .BM_W(BM_W), .PM_W(PM_W), .DEPTH(DEPTH), .PM_INIT(PM_INIT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(ready_o), .bm0_i(bm0_i), .bm1_i(bm1_i), .valid_o(valid_o),
    .ready_i(ready_i), .data_o(data_o), .min_idx_o(min_idx_o), .pm_min_o(pm_min_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_pm(input string tag, input int p0, input int p1, input int p2, input int p3);
    check({tag, "_pm0"}, 32'(dut.pm_q[0]), p0);
    check({tag, "_pm1"}, 32'(dut.pm_q[1]), p1);
    check({tag, "_pm2"}, 32'(dut.pm_q[2]), p2);
    check({tag, "_pm3"}, 32'(dut.pm_q[3]), p3);
  endtask

  function automatic logic [15:0] rep(input logic [3:0] v);
    return {4{v}};
  endfunction

  task automatic step(input logic [15:0] b0, input logic [15:0] b1);
    bm0_i   = b0;
    bm1_i   = b1;
    valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic ideal(input int x);
    if (x != 0) step(rep(4'd2), rep(4'd0));
    else        step(rep(4'd0), rep(4'd2));
  endtask

  initial begin
    rst_i   = 1'b1;
    flush_i = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    bm0_i   = '0;
    bm1_i   = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_ready", ready_o, 1);
    check("rst_idx", min_idx_o, 0);
    check("rst_pmmin", pm_min_o, 0);
    check_pm("rst", 0, PM_INIT, PM_INIT, PM_INIT);

    for (int i = 0; i < 4; i++) begin
      step(rep(4'd0), rep(4'd2));
      check($sformatf("zero_valid%0d", i), valid_o, (i == 3) ? 1 : 0);
    end
    check("zero_data", data_o, 0);
    check("zero_idx", min_idx_o, 0);
    check("zero_pmmin", pm_min_o, 0);
    check_pm("zero", 0, 2, 2, 4);

    flush_i = 1'b1;
    step(rep(4'd15), rep(4'd15));
    flush_i = 1'b0;
    check("flush_valid", valid_o, 0);
    check("flush_pmmin", pm_min_o, 0);
    check_pm("flush", 0, PM_INIT, PM_INIT, PM_INIT);

    for (int i = 0; i < 4; i++) begin
      ideal(bits[i]);
      check($sformatf("ideal_valid%0d", i), valid_o, (i == 3) ? 1 : 0);
    end
    check("ideal_data0", data_o, exp_data[0]);
    check("ideal_idx0", min_idx_o, exp_idx[0]);
    check("ideal_pmmin0", pm_min_o, 0);

    ready_i = 1'b0;
    valid_i = 1'b1;
    bm0_i   = rep(4'd0);
    bm1_i   = rep(4'd2);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk_i);
      #1;
      check($sformatf("bp_ready%0d", c), ready_o, 0);
      check($sformatf("bp_valid%0d", c), valid_o, 1);
      check($sformatf("bp_data%0d", c), data_o, 1);
      check($sformatf("bp_idx%0d", c), min_idx_o, 3);
      check($sformatf("bp_pm0_%0d", c), 32'(dut.pm_q[0]), 4);
    end
    ready_i = 1'b1;
    for (int i = 4; i < 8; i++) begin
      ideal(bits[i]);
      check($sformatf("ideal_valid%0d", i), valid_o, 1);
      check($sformatf("ideal_data%0d", i - 3), data_o, exp_data[i-3]);
      check($sformatf("ideal_idx%0d", i - 3), min_idx_o, exp_idx[i-3]);
      check($sformatf("ideal_pmmin%0d", i - 3), pm_min_o, 0);
    end

    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    step(rep(4'd0), rep(4'd15));
    check_pm("sat1", 0, PM_INIT, 15, 63);
    step(rep(4'd0), rep(4'd15));
    check_pm("sat2", 0, 15, 15, 30);
    for (int i = 0; i < 18; i++) step(rep(4'd0), rep(4'd15));
    check_pm("sat20", 0, 15, 15, 30);
    check("sat_pmmin", pm_min_o, 0);
    check("sat_idx", min_idx_o, 0);

    step({4'd0, 4'd15, 4'd0, 4'd15}, {4'd0, 4'd15, 4'd0, 4'd15});
    check_pm("tie", 15, 30, 15, 30);
    check("tie_idx", min_idx_o, 0);
    check("tie_pmmin", pm_min_o, 15);
    check("tie_surv0", 32'(dut.surv_q[0]), 0);
    check("tie_surv1", 32'(dut.surv_q[1]), 2);
    check("tie_valid", valid_o, 1);

    #3;
    rst_i = 1'b1;
    #1;
    check("arst_valid", valid_o, 0);
    check("arst_pmmin", pm_min_o, 0);
    check("arst_pm1", 32'(dut.pm_q[1]), PM_INIT);
    #2;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
